vedic_seq_mul8: RTL and testbench

VEDIC_SEQ_MUL8 -- requirements
Module: vedic_seq_mul8

---
 rtl/vedic_seq_mul8.sv | 115 +++++++++++
 tb/tb_vedic_seq_mul8.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mul8.sv
// Sequential 8x8 unsigned multiplier built around one shared external 4x4 vedic core.
// Four nibble partial products are accumulated over four cycles (LL, HL, LH, HH).
module vedic_seq_mul8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy,
  output logic [3:0]  core_a,
  output logic [3:0]  core_b,
  input  logic [7:0]  core_p
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    HL   = 3'd2,
    LH   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] pp_shifted;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; all datapath registers are reset so an abort leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Partial product aligned to its nibble weight for the current step.
  always_comb begin
    pp_shifted = 16'h0000;
    unique case (state_q)
      LL:      pp_shifted = {8'h00, core_p};
      HL, LH:  pp_shifted = {4'h0, core_p, 4'h0};
      HH:      pp_shifted = {core_p, 8'h00};
      default: pp_shifted = 16'h0000;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0000;
          state_d = (a == 8'h00 || b == 8'h00) ? DONE : LL;
        end
      end
      LL: begin
        acc_d   = acc_q + pp_shifted;
        state_d = HL;
      end
      HL: begin
        acc_d   = acc_q + pp_shifted;
        state_d = LH;
      end
      LH: begin
        acc_d   = acc_q + pp_shifted;
        state_d = HH;
      end
      HH: begin
        acc_d   = acc_q + pp_shifted;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    product   = (state_q == DONE) ? acc_q : 16'h0000;
    core_a    = 4'h0;
    core_b    = 4'h0;
    unique case (state_q)
      LL: begin core_a = a_q[3:0]; core_b = b_q[3:0]; end
      HL: begin core_a = a_q[7:4]; core_b = b_q[3:0]; end
      LH: begin core_a = a_q[3:0]; core_b = b_q[7:4]; end
      HH: begin core_a = a_q[7:4]; core_b = b_q[7:4]; end
      default: begin core_a = 4'h0; core_b = 4'h0; end
    endcase
  end

endmodule

// File: tb/tb_vedic_seq_mul8.sv
// Directed bench for vedic_seq_mul8; models the external 4x4 core as a plain multiply
// and checks every cycle of each operation against hand-computed values.
module tb_vedic_seq_mul8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [3:0]  core_a, core_b;
  logic [7:0]  core_p;

  int n_cmp = 0;
  int n_err = 0;

  vedic_seq_mul8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_p    (core_p)
  );

  always #5 clk = ~clk;

  assign core_p = {4'h0, core_a} * {4'h0, core_b};

  // Observed/expected vector: {in_ready, out_valid, busy, core_a, core_b, product}
  function automatic logic [26:0] obs();
    return {in_ready, out_valid, busy, core_a, core_b, product};
  endfunction

  function automatic logic [26:0] pk(input logic ir, input logic ov, input logic bz,
                                     input logic [3:0] ca, input logic [3:0] cb,
                                     input logic [15:0] p);
    return {ir, ov, bz, ca, cb, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] exp_v;
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h03; b = 8'h05; out_ready = 1'b0;
    #2;
    exp_v = pk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", obs(), exp_v);
    end
    step(); step();
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", obs(), exp_v);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_idle_after_release: got %h want %h", obs(), exp_v);
    end
  endtask

  // Starts in an IDLE cycle (posedge+1); ends in the IDLE cycle after DONE.
  task automatic run_normal(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic [15:0] exp_p);
    logic [26:0] exp_v;
    logic [3:0]  ea [4];
    logic [3:0]  eb [4];
    ea[0] = ta[3:0]; eb[0] = tb_v[3:0];
    ea[1] = ta[7:4]; eb[1] = tb_v[3:0];
    ea[2] = ta[3:0]; eb[2] = tb_v[7:4];
    ea[3] = ta[7:4]; eb[3] = tb_v[7:4];
    in_valid = 1'b1; a = ta; b = tb_v; out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept_ready: got %b want 1", name, in_ready);
    end
    step();
    // Garbage operands with in_valid held high must not disturb the operation.
    a = ~ta; b = ~tb_v;
    for (int s = 0; s < 4; s++) begin
      exp_v = pk(1'b0, 1'b0, 1'b1, ea[s], eb[s], 16'h0000);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL %s step%0d: got %h want %h", name, s, obs(), exp_v);
      end
      step();
    end
    in_valid = 1'b0;
    exp_v = pk(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, exp_p);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL %s done: got %h want %h", name, obs(), exp_v);
    end
    step();
    exp_v = pk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL %s back_to_idle: got %h want %h", name, obs(), exp_v);
    end
  endtask

  task automatic test_zero(input string name, input logic [7:0] ta, input logic [7:0] tb_v);
    logic [26:0] exp_v;
    in_valid = 1'b1; a = ta; b = tb_v; out_ready = 1'b1;
    exp_v = pk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL %s accept: got %h want %h", name, obs(), exp_v);
    end
    step();
    in_valid = 1'b0;
    exp_v = pk(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL %s done: got %h want %h", name, obs(), exp_v);
    end
    step();
    exp_v = pk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL %s back_to_idle: got %h want %h", name, obs(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    run_normal("b2b_5x3", 8'd5, 8'd3, 16'd15);
    run_normal("b2b_6x8", 8'd6, 8'd8, 16'd48);
  endtask

  task automatic test_stall();
    logic [26:0] exp_v;
    in_valid = 1'b1; a = 8'd4; b = 8'd2; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_early_valid step%0d: got %b want 0", s, out_valid);
      end
      step();
    end
    in_valid = 1'b1; a = 8'd9; b = 8'd9;
    exp_v = pk(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 16'd8);
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL stall_hold cyc%0d: got %h want %h", c, obs(), exp_v);
      end
      step();
    end
    out_ready = 1'b1;
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL stall_release: got %h want %h", obs(), exp_v);
    end
    step();
    run_normal("after_stall_9x9", 8'd9, 8'd9, 16'd81);
  endtask

  task automatic test_reset_mid_op();
    logic [26:0] exp_v;
    in_valid = 1'b1; a = 8'd6; b = 8'd8; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    exp_v = pk(1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL midrst_in_lh: got %h want %h", obs(), exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_v = pk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL midrst_async: got %h want %h", obs(), exp_v);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL midrst_no_pulse cyc%0d: got %h want %h", c, obs(), exp_v);
      end
      step();
    end
    run_normal("after_rst_2x2", 8'd2, 8'd2, 16'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_normal("max_255x255", 8'd255, 8'd255, 16'hFE01);
    test_back_to_back();
    test_zero("zero_0x200", 8'd0, 8'd200);
    test_zero("zero_37x0", 8'd37, 8'd0);
    run_normal("a5x3c", 8'hA5, 8'h3C, 16'h26AC);
    run_normal("10x10", 8'h10, 8'h10, 16'h0100);
    test_stall();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
